// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: operand width, the FUNCT3
// encodings the pipeline decoder also uses, and the divider state type.
package div_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } div_state_e;

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic f3_is_signed(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU.
// Special cases (divide by zero, signed overflow) complete without iterating.
module div_unit #(
    parameter int unsigned XLEN = div_unit_pkg::XLEN
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] DIVIDEND,
    input  logic [XLEN-1:0] DIVISOR,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);
    import div_unit_pkg::*;

    localparam int unsigned   CW       = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    div_state_e      state, state_next;
    logic            accept;

    logic            sel_rem;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] dmag;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [CW-1:0]   cnt;

    logic            in_signed;
    logic            in_rem;
    logic            dvd_neg;
    logic            dvs_neg;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dvs_mag;

    logic [XLEN:0]   rsh;
    logic            ge;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] res_fix;

    always_comb begin
        in_signed   = f3_is_signed(FUNCT3);
        in_rem      = f3_is_rem(FUNCT3);
        dvd_neg     = in_signed && DIVIDEND[XLEN-1];
        dvs_neg     = in_signed && DIVISOR[XLEN-1];
        div_zero    = (DIVISOR == '0);
        ovf         = in_signed && (DIVIDEND == {1'b1, {(XLEN-1){1'b0}}}) && (DIVISOR == '1);
        special     = div_zero || ovf;
        special_res = div_zero ? (in_rem ? DIVIDEND : '1) : (in_rem ? '0 : DIVIDEND);
        dvd_mag     = dvd_neg ? -DIVIDEND : DIVIDEND;
        dvs_mag     = dvs_neg ? -DIVISOR : DIVISOR;
    end

    // One restoring step; the final step also feeds the sign fix-up directly
    // so RESULT is already valid in the FINISH cycle.
    always_comb begin
        rsh      = {rem, quo[XLEN-1]};
        ge       = (rsh >= {1'b0, dmag});
        rem_step = ge ? XLEN'(rsh - {1'b0, dmag}) : rsh[XLEN-1:0];
        quo_step = {quo[XLEN-2:0], ge};
        if (sel_rem)
            res_fix = neg_r ? -rem_step : rem_step;
        else
            res_fix = neg_q ? -quo_step : quo_step;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    accept     = 1'b1;
                    state_next = special ? ST_FINISH : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == '0)
                    state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (FLUSH) begin
            accept     = 1'b0;
            state_next = ST_IDLE;
        end
        BUSY = (state == ST_CALC);
        DONE = (state == ST_FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel_rem <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dmag    <= '0;
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            RESULT  <= '0;
        end else if (!FLUSH) begin
            if (accept) begin
                sel_rem <= in_rem;
                neg_q   <= dvd_neg ^ dvs_neg;
                neg_r   <= dvd_neg;
                dmag    <= dvs_mag;
                quo     <= dvd_mag;
                rem     <= '0;
                cnt     <= CNT_LAST;
                if (special)
                    RESULT <= special_res;
            end else if (state == ST_CALC) begin
                quo <= quo_step;
                rem <= rem_step;
                cnt <= cnt - CW'(1);
                if (cnt == '0)
                    RESULT <= res_fix;
            end
        end
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width in bits.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port START  input  1  EX-stage request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port FUNCT3  input  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port DIVIDEND  input  XLEN  rs1 value (EX_D1 after forwarding).
REQ-007 SHALL have port DIVISOR  input  XLEN  rs2 value (EX_D2 after forwarding).
REQ-008 SHALL have port FLUSH  input  1  pipeline flush; aborts any operation in progress.
REQ-009 SHALL have port BUSY  output  1  high while iterating; the pipeline uses it to stall IF/ID/EX.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse; RESULT is valid for the EX/MEM register.
REQ-011 SHALL have port RESULT  output  XLEN  quotient or remainder as selected by FUNCT3.

Function
REQ-012 SHALL implement states IDLE, CALC and FINISH.
REQ-013 IDLE: START=1 with a normal operand pair -> CALC, with iteration counter = XLEN-1; START=1 with a special case (REQ-018, REQ-019) -> FINISH directly.
REQ-014 START, FUNCT3, DIVIDEND and DIVISOR SHALL be registered at acceptance; later input changes SHALL NOT affect the operation.
REQ-015 CALC: one restoring radix-2 step per cycle on operand magnitudes; counter decrements each cycle; at counter 0 -> FINISH. CALC SHALL last exactly XLEN cycles.
REQ-016 FINISH: DONE=1 and RESULT updated in the same cycle; next state IDLE unconditionally.
REQ-017 Latency: for a normal operation, DONE SHALL be high in cycle XLEN+1 after the START-accept edge (33 for XLEN=32); for a special case, in cycle 1.
REQ-018 Divide by zero: DIV and DIVU SHALL return all ones; REM and REMU SHALL return DIVIDEND.
REQ-019 Signed overflow (DIV/REM, DIVIDEND=0x80000000, DIVISOR=0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-020 Signed sign rules: the quotient SHALL be negated when operand signs differ; the remainder SHALL take the sign of DIVIDEND. Quotients truncate toward zero.
REQ-021 BUSY SHALL be 1 in CALC only; BUSY SHALL be 0 in IDLE and FINISH.
REQ-022 START SHALL be ignored in CALC and FINISH. Back-to-back operations therefore begin no earlier than the cycle after FINISH.
REQ-023 FLUSH=1 SHALL force IDLE at the next edge from any state, with no DONE pulse. FLUSH SHALL take priority over START in the same cycle.
REQ-024 RESULT SHALL hold its last value until the next FINISH.

Reset
REQ-025 When RESET=1 at a rising edge, the unit SHALL enter IDLE and set BUSY=0, DONE=0, RESULT=0, and clear the counter and working registers.
REQ-026 RESET SHALL have priority over FLUSH and START, and SHALL abort an operation mid-CALC with no DONE pulse.

Structure
REQ-027 A shared package SHALL hold XLEN, the FUNCT3 encodings (DIV/DIVU/REM/REMU) and the state enum; the pipeline decoder SHALL import the same encodings.
REQ-028 The block SHALL be a single module with no sub-modules; the sign fix-up SHALL be inline combinational logic feeding the FINISH register.

Verification
REQ-029 DIVU 100/7 -> BUSY for 32 cycles, DONE at cycle 33, RESULT=14; REMU 100/7 -> RESULT=2.
REQ-030 DIV 0xFFFFFFEC (-20) / 3 -> RESULT=0xFFFFFFFA (-6); REM of the same operands -> RESULT=0xFFFFFFFE (-2).
REQ-031 DIV 5/0 -> DONE at cycle 1, RESULT=0xFFFFFFFF, BUSY never high; REMU 5/0 -> RESULT=5.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> RESULT=0x80000000 at cycle 1; REM of the same operands -> RESULT=0.
REQ-033 DIVU started, FLUSH at CALC cycle 10 -> BUSY=0 next cycle, no DONE, RESULT unchanged; a new START next cycle completes correctly.
REQ-034 RESET asserted at CALC cycle 20 -> IDLE, outputs zero; START held high during CALC -> ignored, exactly one DONE.
